// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 character-LCD controller with init sequencer and cursor tracking
module lcd_hd44780_ctrl #(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int T_SETUP   = 25,
    parameter int T_PULSE   = 50,
    parameter int T_HOLD    = 25,
    parameter int T_EXEC    = 2500,
    parameter int T_CLEAR   = 100000,
    parameter int T_POWERON = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_kind,
    input  logic [7:0] wr_data,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       init_done,
    output logic [1:0] cur_row,
    output logic [5:0] cur_col
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = imax(imax(imax(T_SETUP, T_PULSE), imax(T_HOLD, T_EXEC)),
                                imax(T_CLEAR, T_POWERON));
    localparam int CW = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] SETUP_M1 = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_M1 = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_M1  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] EXEC_M1  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] CLEAR_M1 = CW'(T_CLEAR - 1);
    localparam logic [CW-1:0] PWR_M1   = CW'(T_POWERON - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    localparam logic [1:0] KIND_CHAR = 2'b00;
    localparam logic [1:0] KIND_CMD  = 2'b01;
    localparam logic [1:0] KIND_GOTO = 2'b10;

    // INIT doubles as the setup phase for the power-on command list
    typedef enum logic [2:0] {
        S_PWRON,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_WRAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_e_q, lcd_e_d;
    logic          init_done_q, init_done_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [1:0]    cur_row_q, cur_row_d;
    logic [5:0]    cur_col_q, cur_col_d;
    logic [1:0]    pend_row_q, pend_row_d;
    logic [5:0]    pend_col_q, pend_col_d;
    logic          wrap_need_q, wrap_need_d;
    logic          wrap_cyc_q, wrap_cyc_d;
    logic          use_clear_q, use_clear_d;

    logic [1:0]    g_row;
    logic [5:0]    g_col;
    logic [6:0]    g_addr;
    logic [CW-1:0] wait_m1;
    logic          is_clear;

    // DDRAM start address of each display row
    function automatic logic [6:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'(COLS);
            default: return 7'(64 + COLS);
        endcase
    endfunction

    // Power-on command list: function set, display on, entry mode, clear
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return (ROWS > 1) ? 8'h38 : 8'h30;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Goto target clamped into the visible area, plus its DDRAM address
    always_comb begin
        g_row = wr_data[7:6];
        g_col = wr_data[5:0];
        if (int'(wr_data[7:6]) >= ROWS) g_row = 2'(ROWS - 1);
        if (int'(wr_data[5:0]) >= COLS) g_col = 6'(COLS - 1);
        g_addr   = row_base(g_row) + 7'(g_col);
        is_clear = (wr_data == 8'h01) || (wr_data == 8'h02) || (wr_data == 8'h03);
        wait_m1  = use_clear_q ? CLEAR_M1 : EXEC_M1;
    end

    // Next-state, bus-cycle sequencing and cursor bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        pend_row_d  = pend_row_q;
        pend_col_d  = pend_col_q;
        wrap_need_d = wrap_need_q;
        wrap_cyc_d  = wrap_cyc_q;
        use_clear_d = use_clear_q;

        case (state_q)
            S_PWRON: begin
                if (cnt_q == PWR_M1) begin
                    state_d     = S_INIT;
                    cnt_d       = CNT_ZERO;
                    init_idx_d  = 2'd0;
                    lcd_data_d  = init_cmd(2'd0);
                    lcd_rs_d    = 1'b0;
                    use_clear_d = 1'b0;
                end
            end
            S_INIT, S_SETUP: begin
                if (cnt_q == SETUP_M1) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_ZERO;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_M1) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_ZERO;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_M1) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_ZERO;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_m1) begin
                    cnt_d = CNT_ZERO;
                    if (!init_done_q) begin
                        if (init_idx_q == 2'd3) begin
                            state_d     = S_IDLE;
                            init_done_d = 1'b1;
                        end else begin
                            state_d     = S_INIT;
                            init_idx_d  = init_idx_q + 2'd1;
                            lcd_data_d  = init_cmd(init_idx_q + 2'd1);
                            lcd_rs_d    = 1'b0;
                            use_clear_d = (init_idx_q == 2'd2);
                        end
                    end else if (wrap_cyc_q) begin
                        state_d    = S_IDLE;
                        wrap_cyc_d = 1'b0;
                        cur_row_d  = pend_row_q;
                        cur_col_d  = pend_col_q;
                    end else begin
                        state_d = S_WRAP;
                    end
                end
            end
            S_WRAP: begin
                cnt_d = CNT_ZERO;
                if (wrap_need_q) begin
                    state_d     = S_SETUP;
                    lcd_data_d  = 8'h80 | {1'b0, row_base(pend_row_q)};
                    lcd_rs_d    = 1'b0;
                    use_clear_d = 1'b0;
                    wrap_need_d = 1'b0;
                    wrap_cyc_d  = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                    cur_row_d = pend_row_q;
                    cur_col_d = pend_col_q;
                end
            end
            default: begin
                cnt_d = CNT_ZERO;
                if (wr_valid) begin
                    pend_row_d  = cur_row_q;
                    pend_col_d  = cur_col_q;
                    wrap_need_d = 1'b0;
                    use_clear_d = 1'b0;
                    case (wr_kind)
                        KIND_CHAR: begin
                            state_d    = S_SETUP;
                            lcd_data_d = wr_data;
                            lcd_rs_d   = 1'b1;
                            if (cur_col_q == 6'(COLS - 1)) begin
                                pend_row_d  = (cur_row_q == 2'(ROWS - 1)) ? 2'd0 : cur_row_q + 2'd1;
                                pend_col_d  = 6'd0;
                                wrap_need_d = 1'b1;
                            end else begin
                                pend_col_d = cur_col_q + 6'd1;
                            end
                        end
                        KIND_CMD: begin
                            state_d     = S_SETUP;
                            lcd_data_d  = wr_data;
                            lcd_rs_d    = 1'b0;
                            use_clear_d = is_clear;
                            if (is_clear) begin
                                pend_row_d = 2'd0;
                                pend_col_d = 6'd0;
                            end
                        end
                        KIND_GOTO: begin
                            state_d    = S_SETUP;
                            lcd_data_d = 8'h80 | {1'b0, g_addr};
                            lcd_rs_d   = 1'b0;
                            pend_row_d = g_row;
                            pend_col_d = g_col;
                        end
                        default: begin
                            state_d = S_WRAP;
                        end
                    endcase
                end
            end
        endcase

        lcd_e_d = (state_d == S_PULSE);
    end

    // State and output registers, cleared immediately by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PWRON;
            cnt_q       <= '0;
            lcd_data_q  <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            init_done_q <= 1'b0;
            init_idx_q  <= 2'd0;
            cur_row_q   <= 2'd0;
            cur_col_q   <= 6'd0;
            pend_row_q  <= 2'd0;
            pend_col_q  <= 6'd0;
            wrap_need_q <= 1'b0;
            wrap_cyc_q  <= 1'b0;
            use_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_e_q     <= lcd_e_d;
            init_done_q <= init_done_d;
            init_idx_q  <= init_idx_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            pend_row_q  <= pend_row_d;
            pend_col_q  <= pend_col_d;
            wrap_need_q <= wrap_need_d;
            wrap_cyc_q  <= wrap_cyc_d;
            use_clear_q <= use_clear_d;
        end
    end

    assign wr_ready  = (state_q == S_IDLE);
    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = lcd_e_q;
    assign init_done = init_done_q;
    assign cur_row   = cur_row_q;
    assign cur_col   = cur_col_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - directed self-checking bench for lcd_hd44780_ctrl
module tb_lcd_hd44780_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_kind;
    logic [7:0] wr_data;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       init_done;
    logic [1:0] cur_row;
    logic [5:0] cur_col;

    int checks = 0;
    int errors = 0;

    logic [8:0] pq[$];
    int         wq[$];
    logic       e_prev = 1'b0;
    int         wcnt = 0;

    lcd_hd44780_ctrl #(
        .COLS(16), .ROWS(2), .T_SETUP(2), .T_PULSE(4), .T_HOLD(2),
        .T_EXEC(10), .T_CLEAR(40), .T_POWERON(100)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_kind(wr_kind), .wr_data(wr_data),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .init_done(init_done), .cur_row(cur_row), .cur_col(cur_col)
    );

    always #5 clk = ~clk;

    // Capture {rs,data} at each E rise and the E high width at each fall
    always @(posedge clk) begin
        if (lcd_e && !e_prev) begin
            pq.push_back({lcd_rs, lcd_data});
            wcnt <= 1;
        end else if (lcd_e) begin
            wcnt <= wcnt + 1;
        end else if (e_prev) begin
            wq.push_back(wcnt);
        end
        e_prev <= lcd_e;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pulse(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        if (pq.size() > 0) got = pq.pop_front();
        else got = 9'h1FF;
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic expect_width(input string tag);
        int got;
        if (wq.size() > 0) got = wq.pop_front();
        else got = -1;
        chk(tag, got, 4);
    endtask

    task automatic accept(input logic [1:0] kind, input logic [7:0] data);
        wr_valid = 1'b1;
        wr_kind  = kind;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        wr_kind  = 2'b00;
        wr_data  = 8'h00;
    endtask

    task automatic send(input logic [1:0] kind, input logic [7:0] data, output int lat);
        accept(kind, data);
        lat = 0;
        while (!wr_ready && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_init(output int n_done, output int n_rise);
        n_done = 0;
        n_rise = -1;
        while (!init_done && n_done < 1000) begin
            tick();
            n_done++;
            if (lcd_e && n_rise < 0) n_rise = n_done;
        end
    endtask

    task automatic check_init_replay(input string tag);
        int nd, nr;
        wait_init(nd, nr);
        chk({tag, "_done_cycles"}, nd, 202);
        chk({tag, "_first_e_rise"}, nr, 102);
        chk({tag, "_ready"}, 32'(wr_ready), 1);
        expect_pulse({tag, "_cmd0"}, 9'h038);
        expect_pulse({tag, "_cmd1"}, 9'h00C);
        expect_pulse({tag, "_cmd2"}, 9'h006);
        expect_pulse({tag, "_cmd3"}, 9'h001);
        for (int i = 0; i < 4; i++) expect_width({tag, "_e_width"});
    endtask

    initial begin
        int lat, lat15, lat16, n;

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_kind  = 2'b00;
        wr_data  = 8'h00;
        repeat (3) tick();

        chk("rst_lcd_data", 32'(lcd_data), 0);
        chk("rst_lcd_rs", 32'(lcd_rs), 0);
        chk("rst_lcd_rw", 32'(lcd_rw), 0);
        chk("rst_lcd_e", 32'(lcd_e), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_cur_row", 32'(cur_row), 0);
        chk("rst_cur_col", 32'(cur_col), 0);

        rst = 1'b0;
        check_init_replay("init");

        send(2'b00, 8'h41, lat);
        chk("char_latency", lat, 19);
        expect_pulse("char_pulse", 9'h141);
        expect_width("char_e_width");
        chk("char_cur_col", 32'(cur_col), 1);
        chk("char_cur_row", 32'(cur_row), 0);

        send(2'b10, 8'h00, lat);
        expect_pulse("goto00_pulse", 9'h080);
        chk("goto00_cur_col", 32'(cur_col), 0);
        lat15 = 0;
        lat16 = 0;
        for (int i = 0; i < 16; i++) begin
            send(2'b00, 8'(8'h30 + i), lat);
            if (i == 14) begin
                lat15 = lat;
                chk("row0_col_before_last", 32'(cur_col), 15);
            end
            if (i == 15) lat16 = lat;
        end
        chk("row0_lat15", lat15, 19);
        chk("wrap_lat16", lat16, 37);
        for (int i = 0; i < 16; i++) expect_pulse("row0_char", 9'(9'h100 + 9'h030 + i));
        expect_pulse("wrap_cmd_c0", 9'h0C0);
        chk("wrap_cur_row", 32'(cur_row), 1);
        chk("wrap_cur_col", 32'(cur_col), 0);

        for (int i = 0; i < 16; i++) send(2'b00, 8'h61, lat);
        for (int i = 0; i < 16; i++) void'(pq.pop_front());
        expect_pulse("wrap_cmd_80", 9'h080);
        chk("wrap2_cur_row", 32'(cur_row), 0);
        chk("wrap2_cur_col", 32'(cur_col), 0);

        send(2'b10, 8'hF2, lat);
        chk("clamp_latency", lat, 19);
        expect_pulse("clamp_pulse", 9'h0CF);
        chk("clamp_cur_row", 32'(cur_row), 1);
        chk("clamp_cur_col", 32'(cur_col), 15);

        pq.delete();
        send(2'b11, 8'h55, lat);
        chk("kind3_latency", lat, 1);
        chk("kind3_no_pulse", pq.size(), 0);
        chk("kind3_cur_col", 32'(cur_col), 15);

        send(2'b01, 8'h0E, lat);
        chk("rawcmd_latency", lat, 19);
        expect_pulse("rawcmd_pulse", 9'h00E);
        chk("rawcmd_cur_row", 32'(cur_row), 1);
        chk("rawcmd_cur_col", 32'(cur_col), 15);

        send(2'b10, 8'h00, lat);
        for (int i = 0; i < 5; i++) send(2'b00, 8'h42, lat);
        chk("pre_clear_cur_col", 32'(cur_col), 5);
        pq.delete();
        send(2'b01, 8'h01, lat);
        chk("clear_latency", lat, 49);
        expect_pulse("clear_pulse", 9'h001);
        chk("clear_cur_row", 32'(cur_row), 0);
        chk("clear_cur_col", 32'(cur_col), 0);

        send(2'b10, 8'h43, lat);
        chk("goto_r1c3_pulse_pending", pq.size(), 1);
        expect_pulse("goto_r1c3_pulse", 9'h0C3);
        accept(2'b00, 8'h5A);
        chk("busy_ready_low", 32'(wr_ready), 0);
        n = 0;
        while (!lcd_e && n < 100) begin
            tick();
            n++;
        end
        chk("midpulse_e_seen", 32'(lcd_e), 1);
        chk("midpulse_data", 32'(lcd_data), 32'h5A);
        rst = 1'b1;
        #1;
        chk("midrst_lcd_e", 32'(lcd_e), 0);
        chk("midrst_wr_ready", 32'(wr_ready), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        chk("midrst_lcd_data", 32'(lcd_data), 0);
        chk("midrst_cur_col", 32'(cur_col), 0);
        chk("midrst_cur_row", 32'(cur_row), 0);
        repeat (2) tick();
        pq.delete();
        wq.delete();
        rst = 1'b0;
        check_init_replay("reinit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
